// File: rtl/fp8_pkg.sv
// Shared fp8 (1-4-3, bias 7) definitions for the multiplier arbiter and its datapath.
package fp8_pkg;

    localparam int FP8_W    = 8;
    localparam int EXP_W    = 4;
    localparam int MANT_W   = 3;
    localparam int EXP_BIAS = 7;

    localparam logic [FP8_W-1:0] FP8_NAN = 8'h80;
    localparam logic [FP8_W-1:0] FP8_ONE = 8'h38;

    // Widest tag the stage-1 record carries; the arbiter's TAG_W must not exceed it.
    localparam int FP8_TAG_W = 4;

    typedef struct packed {
        logic [FP8_W-1:0]     a;
        logic [FP8_W-1:0]     b;
        logic                 src;
        logic [FP8_TAG_W-1:0] tag;
    } s1_req_t;

    function automatic logic fp8_is_nan(input logic [FP8_W-1:0] v);
        return (v == FP8_NAN);
    endfunction

endpackage

// File: rtl/fp8_mul_arbiter_mul.sv
// Combinational fp8 multiplier: NaN propagates, zero exponent and underflow give +0,
// overflow saturates to +/-max, mantissa rounds to nearest even.
module fp8_mul_arbiter_mul
    import fp8_pkg::*;
(
    input  logic [FP8_W-1:0] a_i,
    input  logic [FP8_W-1:0] b_i,
    output logic [FP8_W-1:0] p_o
);

    logic              sign_s;
    logic [7:0]        mant_prod_s;
    logic              norm_s;
    logic [MANT_W-1:0] keep_s;
    logic              guard_s;
    logic              sticky_s;
    logic              lsb_s;
    logic              round_up_s;
    logic [MANT_W:0]   mant_rnd_s;
    logic [5:0]        exp_raw_s;
    logic [5:0]        exp_unb_s;

    // Multiply significands, normalise, round, then classify special cases.
    always_comb begin
        sign_s      = a_i[7] ^ b_i[7];
        mant_prod_s = {5'b00001, a_i[MANT_W-1:0]} * {5'b00001, b_i[MANT_W-1:0]};
        norm_s      = mant_prod_s[7];
        if (norm_s) begin
            keep_s   = mant_prod_s[6:4];
            guard_s  = mant_prod_s[3];
            sticky_s = |mant_prod_s[2:0];
            lsb_s    = mant_prod_s[4];
        end else begin
            keep_s   = mant_prod_s[5:3];
            guard_s  = mant_prod_s[2];
            sticky_s = |mant_prod_s[1:0];
            lsb_s    = mant_prod_s[3];
        end
        round_up_s = guard_s & (sticky_s | lsb_s);
        mant_rnd_s = {1'b0, keep_s} + {3'b000, round_up_s};
        // A rounding carry out of the mantissa bumps the exponent and leaves mantissa zero.
        exp_raw_s  = {2'b00, a_i[6:3]} + {2'b00, b_i[6:3]} + {5'b00000, norm_s}
                   + {5'b00000, mant_rnd_s[MANT_W]};
        exp_unb_s  = exp_raw_s - 6'(EXP_BIAS);

        if (fp8_is_nan(a_i) || fp8_is_nan(b_i)) begin
            p_o = FP8_NAN;
        end else if ((a_i[6:3] == 4'd0) || (b_i[6:3] == 4'd0)) begin
            p_o = 8'h00;
        end else if (exp_raw_s <= 6'(EXP_BIAS)) begin
            p_o = 8'h00;
        end else if (exp_unb_s[5:4] != 2'b00) begin
            p_o = {sign_s, 7'h7F};
        end else begin
            p_o = {sign_s, exp_unb_s[3:0], mant_rnd_s[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/fp8_mul_arbiter.sv
// Round-robin arbiter feeding one shared fp8 multiplier through a two-stage
// (operand, result) valid/ready pipeline with a tagged response port.
module fp8_mul_arbiter
    import fp8_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    logic             adv1_s;
    logic             adv2_s;
    logic             grant0_s;
    logic             grant1_s;
    logic [7:0]       mul_p_s;

    s1_req_t          s1_d,        s1_q;
    logic             s1_valid_d,  s1_valid_q;
    logic             s2_valid_d,  s2_valid_q;
    logic [7:0]       s2_data_d,   s2_data_q;
    logic             s2_src_d,    s2_src_q;
    logic [TAG_W-1:0] s2_tag_d,    s2_tag_q;
    logic             rr_last_d,   rr_last_q;
    logic [CNT_W-1:0] op_count_d,  op_count_q;
    logic             busy_d,      busy_q;

    fp8_mul_arbiter_mul u_mul (
        .a_i (s1_q.a),
        .b_i (s1_q.b),
        .p_o (mul_p_s)
    );

    // Arbitration, stage advance and next-state computation.
    always_comb begin
        adv2_s   = !s2_valid_q || rsp_ready;
        adv1_s   = !s1_valid_q || adv2_s;
        // rr_last = 1 means requester 1 won last, so requester 0 wins a tie.
        grant0_s = req0_valid && (!req1_valid || rr_last_q);
        grant1_s = req1_valid && !grant0_s;

        req0_ready = grant0_s && adv1_s;
        req1_ready = grant1_s && adv1_s;

        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_src_d   = s2_src_q;
        s2_tag_d   = s2_tag_q;
        rr_last_d  = rr_last_q;
        op_count_d = op_count_q;

        if (adv1_s) begin
            s1_valid_d = grant0_s || grant1_s;
            if (grant1_s) begin
                s1_d.a   = req1_a;
                s1_d.b   = req1_b;
                s1_d.src = 1'b1;
                s1_d.tag = FP8_TAG_W'(req1_tag);
            end else if (grant0_s) begin
                s1_d.a   = req0_a;
                s1_d.b   = req0_b;
                s1_d.src = 1'b0;
                s1_d.tag = FP8_TAG_W'(req0_tag);
            end else begin
                s1_d = s1_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (adv1_s && (grant0_s || grant1_s)) begin
            rr_last_d = grant1_s;
        end else begin
            rr_last_d = rr_last_q;
        end

        // Result fields only reload from a valid S1 so an idle response keeps its last value.
        if (adv2_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = mul_p_s;
                s2_src_d  = s1_q.src;
                s2_tag_d  = s1_q.tag[TAG_W-1:0];
            end else begin
                s2_data_d = s2_data_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (s2_valid_q && rsp_ready) begin
            op_count_d = op_count_q + CNT_W'(1);
        end else begin
            op_count_d = op_count_q;
        end

        busy_d = s1_valid_d || s2_valid_d;
    end

    // Pipeline, arbitration and counter state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= 8'h00;
            s2_src_q   <= 1'b0;
            s2_tag_q   <= '0;
            rr_last_q  <= 1'b1;
            op_count_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_src_q   <= s2_src_d;
            s2_tag_q   <= s2_tag_d;
            rr_last_q  <= rr_last_d;
            op_count_q <= op_count_d;
            busy_q     <= busy_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_data  = s2_data_q;
    assign rsp_src   = s2_src_q;
    assign rsp_tag   = s2_tag_q;
    assign op_count  = op_count_q;
    assign busy      = busy_q;

endmodule
